mux_3input_arbiter: RTL

- Round-robin arbiter that shares the 3-bit, 3-input operand mux between three requesters (A, B, C).
- Drives the mux select `Op` and a one-hot `Grant`. Holds a grant until the owner releases it.
- Sits between the control unit's source-request lines and the mux select input.
- Guarantees the mux is never driven with `Op = 2'b11`.

---
 rtl/mux_3input_arbiter_pkg.sv | 36 +++
 rtl/mux_3input_arbiter_rr_pick_3.sv | 30 +++
 rtl/mux_3input_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mux_3input_arbiter_pkg.sv
// Shared encodings for the 3-input operand-mux arbiter: mux select codes,
// one-hot grant constants, FSM state codes and small index helpers.
package mux_3input_arbiter_pkg;

    localparam logic [1:0] OP_A = 2'b00;
    localparam logic [1:0] OP_B = 2'b01;
    localparam logic [1:0] OP_C = 2'b10;

    localparam logic [2:0] GNT_NONE = 3'b000;
    localparam logic [2:0] GNT_A    = 3'b001;
    localparam logic [2:0] GNT_B    = 3'b010;
    localparam logic [2:0] GNT_C    = 3'b100;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_e;

    // Requester index uses the same encoding as Op (A=0, B=1, C=2).
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        case (idx)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] grant_to_op(input logic [2:0] gnt);
        case (gnt)
            GNT_B:   return OP_B;
            GNT_C:   return OP_C;
            default: return OP_A;
        endcase
    endfunction

endpackage

// File: rtl/mux_3input_arbiter_rr_pick_3.sv
// Combinational round-robin picker: first request set in the order
// ptr, ptr+1, ptr+2 (mod 3), ignoring requesters in the exclude mask.
module rr_pick_3
    import mux_3input_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    input  logic [2:0] excl_i,
    output logic [2:0] win_o,
    output logic       any_o
);

    logic [2:0] cand;
    logic [1:0] idx;

    always_comb begin
        cand  = req_i & ~excl_i;
        win_o = GNT_NONE;
        idx   = (ptr_i == 2'd3) ? 2'd0 : ptr_i;
        for (int k = 0; k < 3; k++) begin
            if (win_o == GNT_NONE && cand[idx]) begin
                win_o[idx] = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

    assign any_o = |cand;

endmodule

// File: rtl/mux_3input_arbiter.sv
// Round-robin arbiter for the shared 3-input operand mux; all outputs are flops.
// Optional hold-time preemption is built when ARB_TIMEOUT_EN is defined.
module mux_3input_arbiter
    import mux_3input_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
)
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [2:0] Req,
    output logic [2:0] Grant,
    output logic [1:0] Op,
    output logic       Valid,
    output logic       Owner_Change
);

    state_e     state_q;
    logic [2:0] grant_q;
    logic [1:0] op_q;
    logic       valid_q;
    logic       owner_change_q;
    logic [1:0] ptr_q;

    logic [1:0] owner_idx;
    logic       owner_req;
    logic [1:0] pick_ptr;
    logic [2:0] pick_excl;
    logic [2:0] pick_win;
    logic       pick_any;
    logic       preempt;

    assign owner_idx = grant_to_op(grant_q);
    assign owner_req = |(Req & grant_q);

    // When idle the pick starts at the stored pointer; on handoff it starts
    // just after the current owner and never re-selects it.
    always_comb begin
        pick_ptr  = ptr_q;
        pick_excl = GNT_NONE;
        if (state_q == ST_GRANTED) begin
            pick_ptr  = next_idx(owner_idx);
            pick_excl = grant_q;
        end
    end

    rr_pick_3 u_pick (
        .req_i  (Req),
        .ptr_i  (pick_ptr),
        .excl_i (pick_excl),
        .win_o  (pick_win),
        .any_o  (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_SAT = '1;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;

    assign preempt = (hold_q == HOLD_LIM) && pick_any;

    always_comb begin
        hold_d = '0;
        if (state_q == ST_GRANTED && owner_req && !preempt) begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= GNT_NONE;
            op_q           <= OP_A;
            valid_q        <= 1'b0;
            owner_change_q <= 1'b0;
            ptr_q          <= 2'd0;
        end else begin
            owner_change_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q        <= pick_win;
                        op_q           <= grant_to_op(pick_win);
                        valid_q        <= 1'b1;
                        owner_change_q <= 1'b1;
                        state_q        <= ST_GRANTED;
                    end
                end
                default: begin
                    if (!owner_req || preempt) begin
                        ptr_q <= next_idx(owner_idx);
                        if (pick_any) begin
                            grant_q        <= pick_win;
                            op_q           <= grant_to_op(pick_win);
                            owner_change_q <= 1'b1;
                        end else begin
                            // Op keeps its last value so the mux output stays put.
                            grant_q <= GNT_NONE;
                            valid_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign Grant        = grant_q;
    assign Op           = op_q;
    assign Valid        = valid_q;
    assign Owner_Change = owner_change_q;

endmodule
